// File: rtl/light_grid_executor.sv
// light_grid_executor: buffers rectangle instructions, applies them to a
// 1-bit-per-cell grid one cell per cycle, then counts lit cells.
module light_grid_executor #(
  parameter int INSTRUCTION_WIDTH = 52,
  parameter int GRID_SIZE         = 1000,
  parameter int FIFO_DEPTH        = 16,
  parameter int COUNT_WIDTH       = 20
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         end_of_file,
  input  logic                         instr_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] instr_data,
  output logic [COUNT_WIDTH-1:0]       lit_count,
  output logic                         done,
  output logic                         overflow,
  output logic                         bad_instr
);

  localparam int CELLS = GRID_SIZE * GRID_SIZE;
  localparam int CW    = $clog2(CELLS);
  // Address counter also has to reach CELLS (one past the end) during COUNT.
  localparam int AW    = $clog2(CELLS + 1);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam logic [11:0] GS12 = 12'(GRID_SIZE);

  // Instruction body without the last/valid flags, which are consumed at push.
  typedef struct packed {
    logic [1:0]  op;
    logic [11:0] sr;
    logic [11:0] sc;
    logic [11:0] er;
    logic [11:0] ec;
  } instr_t;

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_APPLY, S_DRAIN, S_COUNT, S_DONE
  } state_t;

  state_t state, state_nxt;

  // ---------------- instruction FIFO ----------------
  instr_t      fifo_q [FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic        empty, full, push_req, push_ok, pop;
  instr_t      head, body;
  logic        legal;

  assign body     = instr_t'(instr_data[INSTRUCTION_WIDTH-3:0]);
  assign push_req = instr_valid & instr_data[INSTRUCTION_WIDTH-2];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is fine then.
  assign push_ok  = push_req & (~full | pop);
  assign head     = fifo_q[rd_ptr[PW-1:0]];
  assign legal    = (head.op != 2'b10) && (head.sr <= head.er) && (head.sc <= head.ec) &&
                    (head.sr < GS12) && (head.sc < GS12) &&
                    (head.er < GS12) && (head.ec < GS12);

  // FIFO storage (no reset needed; pointers define validity)
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr[PW-1:0]] <= body;
  end

  // FIFO pointers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------- datapath state ----------------
  logic [AW-1:0] addr;
  logic [11:0]   cur_row, cur_col, s_col, e_row, e_col;
  logic [1:0]    ap_op, wb_op;
  logic [CW-1:0] wb_addr, rd_addr, cell_addr, grid_waddr;
  logic          rd_en, rd_vld, rd_wb, rd_data;
  logic          clr_we, grid_we, grid_wdata, eof_seen, last_cell;

  assign cell_addr = CW'(cur_row) * CW'(GRID_SIZE) + CW'(cur_col);
  assign last_cell = (cur_col == e_col) && (cur_row == e_row);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_CLEAR;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (addr == AW'(CELLS - 1)) state_nxt = S_IDLE;
      S_IDLE: begin
        if (!empty) begin
          if (legal) state_nxt = S_APPLY;
        end else if (eof_seen) begin
          state_nxt = S_COUNT;
        end
      end
      S_APPLY: if (last_cell) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_IDLE;
      S_COUNT: if (addr == AW'(CELLS)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_CLEAR;
    endcase
  end

  // Output / control decode
  always_comb begin
    pop     = 1'b0;
    rd_en   = 1'b0;
    rd_addr = '0;
    clr_we  = 1'b0;
    done    = 1'b0;
    case (state)
      S_CLEAR: clr_we = 1'b1;
      S_IDLE:  pop = ~empty;
      S_APPLY: begin
        rd_en   = 1'b1;
        rd_addr = cell_addr;
      end
      S_COUNT: begin
        rd_en   = (addr < AW'(CELLS));
        rd_addr = addr[CW-1:0];
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Single grid write port: CLEAR zeroing or the APPLY write-back
  always_comb begin
    grid_we    = clr_we | (rd_vld & rd_wb);
    grid_waddr = clr_we ? addr[CW-1:0] : wb_addr;
    case (wb_op)
      2'b00:   grid_wdata = 1'b0;
      2'b01:   grid_wdata = ~rd_data;
      default: grid_wdata = 1'b1;
    endcase
    if (clr_we) grid_wdata = 1'b0;
  end

  // Cell storage: sync read, 1-cycle latency, never reset (CLEAR initializes it)
  logic grid_q [CELLS];
  always_ff @(posedge clk) begin
    if (grid_we) grid_q[grid_waddr] <= grid_wdata;
    if (rd_en)   rd_data <= grid_q[rd_addr];
  end

  // Sequencing counters, read pipeline and sticky flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr      <= '0;
      cur_row   <= '0;
      cur_col   <= '0;
      s_col     <= '0;
      e_row     <= '0;
      e_col     <= '0;
      ap_op     <= '0;
      wb_op     <= '0;
      wb_addr   <= '0;
      rd_vld    <= 1'b0;
      rd_wb     <= 1'b0;
      lit_count <= '0;
      eof_seen  <= 1'b0;
      overflow  <= 1'b0;
      bad_instr <= 1'b0;
    end else begin
      rd_vld  <= rd_en;
      rd_wb   <= (state == S_APPLY);
      wb_addr <= rd_addr;
      wb_op   <= ap_op;
      if (end_of_file || (push_req && instr_data[INSTRUCTION_WIDTH-1])) eof_seen <= 1'b1;
      if (push_req && !push_ok) overflow <= 1'b1;
      if (rd_vld && !rd_wb) lit_count <= lit_count + COUNT_WIDTH'(rd_data);
      case (state)
        S_CLEAR: addr <= addr + 1'b1;
        S_IDLE: begin
          if (!empty) begin
            if (legal) begin
              cur_row <= head.sr;
              cur_col <= head.sc;
              s_col   <= head.sc;
              e_row   <= head.er;
              e_col   <= head.ec;
              ap_op   <= head.op;
            end else begin
              bad_instr <= 1'b1;
            end
          end else if (eof_seen) begin
            addr      <= '0;
            lit_count <= '0;
          end
        end
        S_APPLY: begin
          if (cur_col == e_col) begin
            cur_col <= s_col;
            cur_row <= cur_row + 1'b1;
          end else begin
            cur_col <= cur_col + 1'b1;
          end
        end
        S_COUNT: if (addr != AW'(CELLS)) addr <= addr + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_light_grid_executor.sv
// Directed bench for light_grid_executor on an 8x8 grid.
module tb_light_grid_executor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        end_of_file;
  logic        instr_valid;
  logic [51:0] instr_data;
  logic [19:0] lit_count;
  logic        done, overflow, bad_instr;

  int n_cmp = 0;
  int n_err = 0;

  light_grid_executor #(
    .INSTRUCTION_WIDTH(52), .GRID_SIZE(8), .FIFO_DEPTH(16), .COUNT_WIDTH(20)
  ) dut (
    .clk(clk), .reset_n(reset_n), .end_of_file(end_of_file),
    .instr_valid(instr_valid), .instr_data(instr_data),
    .lit_count(lit_count), .done(done), .overflow(overflow), .bad_instr(bad_instr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  function automatic logic [51:0] mk(input logic last, input logic [1:0] op,
                                     input int sr, input int sc, input int er, input int ec);
    return {last, 1'b1, op, 12'(sr), 12'(sc), 12'(er), 12'(ec)};
  endfunction

  task automatic push(input logic [51:0] d);
    instr_valid = 1'b1;
    instr_data  = d;
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic eof();
    end_of_file = 1'b1;
    @(posedge clk); #1;
    end_of_file = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    end_of_file = 1'b0;
    instr_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_rst_done"}, 32'(done), 0);
    chk({tag, "_rst_ovf"},  32'(overflow), 0);
    chk({tag, "_rst_bad"},  32'(bad_instr), 0);
    chk({tag, "_rst_cnt"},  32'(lit_count), 0);
    reset_n = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int k;
    for (k = 0; k < 3000; k++) begin
      if (done) break;
      @(posedge clk); #1;
    end
    chk({tag, "_done"}, 32'(done), 1);
  endtask

  initial begin
    reset_n = 1'b1; end_of_file = 1'b0; instr_valid = 1'b0; instr_data = '0;

    // all on, pushed and eof'd during CLEAR
    do_reset("t1");
    push(mk(0, 2'b11, 0, 0, 7, 7));
    eof();
    chk("t1_early_done", 32'(done), 0);
    wait_done("t1");
    chk("t1_cnt", 32'(lit_count), 64);

    // on all, toggle column 0, off 2x2 centre -> 64-8-4
    do_reset("t2");
    push(mk(0, 2'b11, 0, 0, 7, 7));
    push(mk(0, 2'b01, 0, 0, 7, 0));
    push(mk(0, 2'b00, 3, 3, 4, 4));
    eof();
    wait_done("t2");
    chk("t2_cnt", 32'(lit_count), 52);
    chk("t2_bad", 32'(bad_instr), 0);

    // illegal instructions only
    do_reset("t3");
    push(mk(0, 2'b10, 0, 0, 1, 1));
    push(mk(0, 2'b11, 5, 0, 2, 3));
    push(mk(0, 2'b11, 0, 0, 0, 8));
    eof();
    wait_done("t3");
    chk("t3_cnt", 32'(lit_count), 0);
    chk("t3_bad", 32'(bad_instr), 1);

    // back-to-back toggles on overlapping cells: (0,0) x4 -> off, (0,1) x3 -> on
    do_reset("t4");
    push(mk(0, 2'b01, 0, 0, 0, 1));
    push(mk(0, 2'b01, 0, 0, 0, 1));
    push(mk(0, 2'b01, 0, 0, 0, 1));
    push(mk(0, 2'b01, 0, 0, 0, 0));
    eof();
    wait_done("t4");
    chk("t4_cnt", 32'(lit_count), 1);

    // 17 pushes during CLEAR: rows 0-1 single cells accepted, (2,0) dropped
    do_reset("t5");
    for (int k = 0; k < 16; k++) push(mk(0, 2'b11, k >> 3, k & 7, k >> 3, k & 7));
    chk("t5_ovf_at16", 32'(overflow), 0);
    push(mk(0, 2'b11, 2, 0, 2, 0));
    chk("t5_ovf_at17", 32'(overflow), 1);
    eof();
    wait_done("t5");
    chk("t5_cnt", 32'(lit_count), 16);

    // reset mid-APPLY, then a fresh 2x2
    do_reset("t6a");
    push(mk(0, 2'b11, 0, 0, 7, 7));
    eof();
    repeat (80) @(posedge clk);
    #1;
    do_reset("t6b");
    push(mk(0, 2'b11, 1, 1, 2, 2));
    eof();
    wait_done("t6");
    chk("t6_cnt", 32'(lit_count), 4);

    // last flag alone ends the run: toggle 3x4 block
    do_reset("t7");
    push(mk(1, 2'b01, 2, 2, 4, 5));
    wait_done("t7");
    chk("t7_cnt", 32'(lit_count), 12);

    // in DONE: grid frozen, FIFO fills and then overflows
    for (int k = 0; k < 16; k++) push(mk(0, 2'b11, 0, 0, 7, 7));
    chk("t8_ovf_at16", 32'(overflow), 0);
    push(mk(0, 2'b11, 0, 0, 7, 7));
    chk("t8_ovf_at17", 32'(overflow), 1);
    repeat (200) @(posedge clk);
    #1;
    chk("t8_cnt_held", 32'(lit_count), 12);
    chk("t8_done_held", 32'(done), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
